// File: rtl/cache_way_array.sv
// cache_way_array: 2-way set-associative tag/data array with hit detection,
// CPU byte-write merge and write-back / line-fill sequencing to physical memory.
module cache_way_array #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [127:0] way0_line,
  output logic [127:0] way1_line,
  output logic         way_select,
  output logic [3:0]   word_offset,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NUM_SETS = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 12 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [TAG_BITS-1:0] tag_r   [2][NUM_SETS];
  logic [127:0]        data_r  [2][NUM_SETS];
  logic [NUM_SETS-1:0] valid_r [2];
  logic [NUM_SETS-1:0] dirty_r [2];
  logic [NUM_SETS-1:0] lru_r;

  logic [TAG_BITS-1:0]   addr_tag_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic                  req_s;
  logic                  hit_w0_s;
  logic                  hit_w1_s;
  logic                  hit_s;
  logic                  victim_s;
  logic                  victim_dirty_s;
  logic                  hit_update_s;
  logic                  wr_merge_s;
  logic                  fill_done_s;
  logic [127:0]          hit_line_s;
  logic [127:0]          merged_line_s;

  // Overlay the enabled bytes of one 16-bit word onto a line; byte 0 is line[7:0].
  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [2:0]   word,
                                              input logic [1:0]   be,
                                              input logic [15:0]  wdata);
    logic [127:0] res;
    res = line;
    res[{word, 4'b0000} +: 8] = be[0] ? wdata[7:0]  : line[{word, 4'b0000} +: 8];
    res[{word, 4'b1000} +: 8] = be[1] ? wdata[15:8] : line[{word, 4'b1000} +: 8];
    return res;
  endfunction

  assign addr_tag_s  = mem_address[15:4+INDEX_BITS];
  assign idx_s       = mem_address[3+INDEX_BITS:4];
  assign word_offset = mem_address[3:0];
  assign req_s       = mem_read | mem_write;

  assign hit_w0_s   = valid_r[0][idx_s] && (tag_r[0][idx_s] == addr_tag_s);
  assign hit_w1_s   = valid_r[1][idx_s] && (tag_r[1][idx_s] == addr_tag_s);
  assign hit_s      = hit_w0_s | hit_w1_s;
  assign way_select = hit_w1_s;
  assign way0_line  = data_r[0][idx_s];
  assign way1_line  = data_r[1][idx_s];

  // The victim is re-derived each cycle from the held address; lru only moves on hits,
  // so it stays fixed for the whole miss.
  assign victim_s       = lru_r[idx_s];
  assign victim_dirty_s = valid_r[victim_s][idx_s] && dirty_r[victim_s][idx_s];

  assign hit_update_s  = (state_r == IDLE) && req_s && hit_s;
  assign wr_merge_s    = hit_update_s && mem_write && (mem_byte_enable != 2'b00);
  assign fill_done_s   = (state_r == FILL) && pmem_resp;
  assign hit_line_s    = hit_w1_s ? data_r[1][idx_s] : data_r[0][idx_s];
  assign merged_line_s = merge_word(hit_line_s, mem_address[3:1], mem_byte_enable, mem_wdata);

  // Next-state and handshake outputs for the miss sequencer.
  always_comb begin
    state_next_s = state_r;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {addr_tag_s, idx_s, 4'h0};
    pmem_wdata   = data_r[victim_s][idx_s];
    case (state_r)
      IDLE: begin
        if (!req_s) begin
          state_next_s = IDLE;
        end else if (hit_s) begin
          mem_resp     = 1'b1;
          state_next_s = IDLE;
        end else if (victim_dirty_s) begin
          state_next_s = WRITEBACK;
        end else begin
          state_next_s = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_r[victim_s][idx_s], idx_s, 4'h0};
        if (pmem_resp) begin
          state_next_s = FILL;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = FILL;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and per-set status bits (valid, dirty, lru).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      valid_r[0] <= {NUM_SETS{1'b0}};
      valid_r[1] <= {NUM_SETS{1'b0}};
      dirty_r[0] <= {NUM_SETS{1'b0}};
      dirty_r[1] <= {NUM_SETS{1'b0}};
      lru_r      <= {NUM_SETS{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (hit_update_s) begin
        lru_r[idx_s] <= ~hit_w1_s;
      end
      if (wr_merge_s) begin
        dirty_r[hit_w1_s][idx_s] <= 1'b1;
      end
      if (fill_done_s) begin
        valid_r[victim_s][idx_s] <= 1'b1;
        dirty_r[victim_s][idx_s] <= 1'b0;
      end
    end
  end

  // Tag and data storage: not reset, and never written while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && fill_done_s) begin
      data_r[victim_s][idx_s] <= pmem_rdata;
      tag_r[victim_s][idx_s]  <= addr_tag_s;
    end else if (reset_n && wr_merge_s) begin
      data_r[hit_w1_s][idx_s] <= merged_line_s;
    end
  end

endmodule
